// File: rtl/ras_pkg.sv
// Shared types and constants for the return address stack controller.
package ras_pkg;

    typedef enum logic {
        RUN,
        FLUSH
    } ras_ctrl_state_e;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } ras_op_e;

    localparam int RVC_LEN = 2;
    localparam int RVI_LEN = 4;

endpackage

// File: rtl/ras_ctrl_perf.sv
// Event counter bank for the RAS controller (used when RAS_CTRL_PERF_EN is defined).
module ras_ctrl_perf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        call_evt_i,
    input  logic        ret_evt_i,
    input  logic        unf_evt_i,
    input  logic        ovf_evt_i,
    output logic [31:0] perf_call_o,
    output logic [31:0] perf_ret_o,
    output logic [31:0] perf_unf_o,
    output logic [31:0] perf_ovf_o
);

    // Counters wrap naturally and survive stack flushes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_call_o <= '0;
            perf_ret_o  <= '0;
            perf_unf_o  <= '0;
            perf_ovf_o  <= '0;
        end else begin
            if (call_evt_i) perf_call_o <= perf_call_o + 32'd1;
            if (ret_evt_i)  perf_ret_o  <= perf_ret_o + 32'd1;
            if (unf_evt_i)  perf_unf_o  <= perf_unf_o + 32'd1;
            if (ovf_evt_i)  perf_ovf_o  <= perf_ovf_o + 32'd1;
        end
    end

endmodule

// File: rtl/ras_ctrl.sv
// Return address stack sequencing controller: push/pop/flush strobes, occupancy and prediction.
// Optional event counters are built when RAS_CTRL_PERF_EN is defined.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int DATA_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            call_vld_i,
    input  logic [DATA_WIDTH-1:0]           call_pc_i,
    input  logic                            call_rvc_i,
    input  logic                            ret_vld_i,
    output logic                            req_rdy_o,
    output logic                            ras_push_o,
    output logic                            ras_pop_o,
    output logic                            ras_flush_o,
    output logic [DATA_WIDTH-1:0]           ras_wdata_o,
    input  logic                            ras_top_vld_i,
    input  logic [DATA_WIDTH-1:0]           ras_top_i,
    output logic                            pred_vld_o,
    output logic [DATA_WIDTH-1:0]           pred_target_o,
    output logic                            ret_nopred_o,
    output logic [$clog2(DATA_DEPTH+1)-1:0] occ_o,
    output logic                            overflow_o,
    output logic [31:0]                     perf_call_o,
    output logic [31:0]                     perf_ret_o,
    output logic [31:0]                     perf_unf_o,
    output logic [31:0]                     perf_ovf_o
);

    localparam int OCC_W = $clog2(DATA_DEPTH + 1);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    ras_ctrl_state_e        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   ovf_q, ovf_d;
    logic                   pred_vld_p1, ret_nopred_p1;
    logic [DATA_WIDTH-1:0]  pred_target_p1;

    logic    call_acc, ret_acc, ret_hit, occ_full;
    ras_op_e op;

    function automatic logic [DATA_WIDTH-1:0] ret_addr(input logic [DATA_WIDTH-1:0] pc,
                                                       input logic rvc);
        return pc + (rvc ? DATA_WIDTH'(RVC_LEN) : DATA_WIDTH'(RVI_LEN));
    endfunction

    assign req_rdy_o = (state_q == RUN) && !flush_i;
    assign call_acc  = call_vld_i && req_rdy_o;
    assign ret_acc   = ret_vld_i && req_rdy_o;
    // An invalid top entry is handled exactly like an empty stack.
    assign ret_hit   = (occ_q != '0) && ras_top_vld_i;
    assign occ_full  = (occ_q == OCC_W'(DATA_DEPTH));

    always_comb begin
        op = OP_NONE;
        if (call_acc && ret_acc) op = OP_REPL;
        else if (call_acc)       op = OP_PUSH;
        else if (ret_acc && ret_hit) op = OP_POP;
    end

    assign ras_push_o  = (op == OP_PUSH) || (op == OP_REPL);
    assign ras_pop_o   = (op == OP_POP) || ((op == OP_REPL) && ret_hit);
    assign ras_flush_o = flush_i;
    assign ras_wdata_o = ret_addr(call_pc_i, call_rvc_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        occ_d   = occ_q;
        ovf_d   = ovf_q;
        if (flush_i) begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            occ_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    unique case (op)
                        OP_PUSH: begin
                            if (occ_full) ovf_d = 1'b1;
                            else          occ_d = occ_q + OCC_W'(1);
                        end
                        OP_POP:  occ_d = occ_q - OCC_W'(1);
                        OP_REPL: if (occ_q == '0) occ_d = OCC_W'(1);
                        default: ;
                    endcase
                end
                FLUSH: begin
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Stage p1: prediction registered one cycle after the return is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_vld_p1    <= 1'b0;
            ret_nopred_p1  <= 1'b0;
            pred_target_p1 <= '0;
        end else begin
            pred_vld_p1   <= ret_acc && ret_hit;
            ret_nopred_p1 <= ret_acc && !ret_hit;
            if (ret_acc && ret_hit) pred_target_p1 <= ras_top_i;
        end
    end

    // A flush arriving with the pulse cancels it.
    assign pred_vld_o    = pred_vld_p1 && !flush_i;
    assign ret_nopred_o  = ret_nopred_p1 && !flush_i;
    assign pred_target_o = pred_target_p1;
    assign occ_o         = occ_q;
    assign overflow_o    = ovf_q;

`ifdef RAS_CTRL_PERF_EN
    ras_ctrl_perf u_perf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .call_evt_i  (call_acc),
        .ret_evt_i   (ret_acc),
        .unf_evt_i   (ret_acc && !ret_hit),
        .ovf_evt_i   ((op == OP_PUSH) && occ_full),
        .perf_call_o (perf_call_o),
        .perf_ret_o  (perf_ret_o),
        .perf_unf_o  (perf_unf_o),
        .perf_ovf_o  (perf_ovf_o)
    );
`else
    assign perf_call_o = '0;
    assign perf_ret_o  = '0;
    assign perf_unf_o  = '0;
    assign perf_ovf_o  = '0;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Testbench for ras_ctrl: directed scenarios plus random traffic against a queue-based stack model.
module tb_ras_ctrl;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int FC    = 2;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             call_vld_i = 1'b0;
    logic [DW-1:0]    call_pc_i = '0;
    logic             call_rvc_i = 1'b0;
    logic             ret_vld_i = 1'b0;
    logic             req_rdy_o, ras_push_o, ras_pop_o, ras_flush_o;
    logic [DW-1:0]    ras_wdata_o;
    logic             ras_top_vld_i = 1'b0;
    logic [DW-1:0]    ras_top_i = '0;
    logic             pred_vld_o, ret_nopred_o, overflow_o;
    logic [DW-1:0]    pred_target_o;
    logic [OCC_W-1:0] occ_o;
    logic [31:0]      perf_call_o, perf_ret_o, perf_unf_o, perf_ovf_o;

    ras_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .call_vld_i(call_vld_i), .call_pc_i(call_pc_i), .call_rvc_i(call_rvc_i),
        .ret_vld_i(ret_vld_i), .req_rdy_o(req_rdy_o),
        .ras_push_o(ras_push_o), .ras_pop_o(ras_pop_o), .ras_flush_o(ras_flush_o),
        .ras_wdata_o(ras_wdata_o), .ras_top_vld_i(ras_top_vld_i), .ras_top_i(ras_top_i),
        .pred_vld_o(pred_vld_o), .pred_target_o(pred_target_o), .ret_nopred_o(ret_nopred_o),
        .occ_o(occ_o), .overflow_o(overflow_o),
        .perf_call_o(perf_call_o), .perf_ret_o(perf_ret_o),
        .perf_unf_o(perf_unf_o), .perf_ovf_o(perf_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: the stack itself (top at the back) plus bookkeeping.
    logic [DW-1:0] m_stack[$];
    bit            m_ovf;
    int            m_blocked;
    bit            m_hit_prev, m_miss_prev;
    logic [DW-1:0] m_target;
    int unsigned   m_pcall, m_pret, m_punf, m_povf;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stack.delete();
        m_ovf = 0; m_blocked = 0; m_hit_prev = 0; m_miss_prev = 0; m_target = '0;
        m_pcall = 0; m_pret = 0; m_punf = 0; m_povf = 0;
    endtask

    task automatic chk_perf();
`ifdef RAS_CTRL_PERF_EN
        chk("perf_call", DW'(perf_call_o), DW'(m_pcall));
        chk("perf_ret",  DW'(perf_ret_o),  DW'(m_pret));
        chk("perf_unf",  DW'(perf_unf_o),  DW'(m_punf));
        chk("perf_ovf",  DW'(perf_ovf_o),  DW'(m_povf));
`else
        chk("perf_tied", DW'({perf_call_o, perf_ret_o} | {perf_unf_o, perf_ovf_o}), '0);
`endif
    endtask

    // Asynchronous reset in the middle of a low clock phase; outputs checked before any edge.
    task automatic do_reset();
        @(negedge clk_i);
        flush_i = 0; call_vld_i = 0; ret_vld_i = 0; ras_top_vld_i = 0;
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        chk("rst_occ",    DW'(occ_o), '0);
        chk("rst_ovf",    DW'(overflow_o), '0);
        chk("rst_pvld",   DW'(pred_vld_o), '0);
        chk("rst_ptgt",   pred_target_o, '0);
        chk("rst_nopred", DW'(ret_nopred_o), '0);
        chk("rst_rdy",    DW'(req_rdy_o), 64'd1);
        chk_perf();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cycle(input bit fl, input bit cv, input logic [DW-1:0] pc,
                         input bit rvc, input bit rv, input bit tv_zero);
        bit            rdy, ca, ra, hit;
        logic [DW-1:0] addr, top;
        @(negedge clk_i);
        top = (m_stack.size() > 0) ? m_stack[$] : {$urandom, $urandom};
        flush_i = fl; call_vld_i = cv; call_pc_i = pc; call_rvc_i = rvc; ret_vld_i = rv;
        ras_top_vld_i = (m_stack.size() > 0) && !tv_zero;
        ras_top_i = top;
        #1;
        rdy  = (m_blocked == 0) && !fl;
        ca   = cv && rdy;
        ra   = rv && rdy;
        hit  = ra && ras_top_vld_i;
        addr = pc + (rvc ? 64'd2 : 64'd4);

        chk("req_rdy",   DW'(req_rdy_o), DW'(rdy));
        chk("push",      DW'(ras_push_o), DW'(ca));
        chk("pop",       DW'(ras_pop_o), DW'(hit));
        chk("flush",     DW'(ras_flush_o), DW'(fl));
        if (ca) chk("wdata", ras_wdata_o, addr);
        chk("pred_vld",  DW'(pred_vld_o), DW'(m_hit_prev && !fl));
        chk("nopred",    DW'(ret_nopred_o), DW'(m_miss_prev && !fl));
        chk("pred_tgt",  pred_target_o, m_target);
        chk("occ",       DW'(occ_o), DW'(m_stack.size()));
        chk("overflow",  DW'(overflow_o), DW'(m_ovf));
        chk_perf();

        if (ca) m_pcall++;
        if (ra) m_pret++;
        if (ra && !hit) m_punf++;
        if (ca && !ra && m_stack.size() == DEPTH) m_povf++;

        if (fl) begin
            m_stack.delete(); m_ovf = 0; m_blocked = FC;
        end else if (m_blocked > 0) begin
            m_blocked--;
        end else begin
            if (hit) m_target = top;
            if (ca && ra) begin
                if (hit) m_stack[m_stack.size()-1] = addr;
                else     m_stack.push_back(addr);
            end else if (ca) begin
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1;
                end
                m_stack.push_back(addr);
            end else if (hit) begin
                void'(m_stack.pop_back());
            end
        end
        m_hit_prev  = hit;
        m_miss_prev = ra && !hit;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Two calls of different lengths, then two returns.
        cycle(0, 1, 64'h1000, 0, 0, 0);
        cycle(0, 1, 64'h2000, 1, 0, 0);
        cycle(0, 0, '0, 0, 1, 0);
        cycle(0, 0, '0, 0, 1, 0);
        idle(1);
        chk("lifo_tgt", pred_target_o, 64'h1004);

        // Overflow past depth, drain in LIFO order, then underflow.
        for (int i = 0; i < 5; i++) cycle(0, 1, 64'h100 * (i + 1), 0, 0, 0);
        idle(1);
        chk("ovf_set", DW'(overflow_o), 64'd1);
        chk("occ_sat", DW'(occ_o), 64'd4);
        for (int i = 0; i < 5; i++) cycle(0, 0, '0, 0, 1, 0);
        idle(1);

        // Co-routine swap at occupancy 2 with top 0xA0.
        cycle(0, 1, 64'h3000, 0, 0, 0);
        cycle(0, 1, 64'h9C, 0, 0, 0);
        cycle(0, 1, 64'h5000, 1, 1, 0);
        idle(1);
        chk("swap_tgt", pred_target_o, 64'hA0);

        // Flush at occupancy 3 with a colliding call, then a re-flush inside the window.
        cycle(0, 1, 64'h40, 0, 0, 0);
        cycle(1, 1, 64'h80, 0, 0, 0);
        idle(3);
        cycle(0, 1, 64'h4000, 0, 0, 0);
        cycle(0, 1, 64'h4100, 0, 1, 0);
        cycle(1, 0, '0, 0, 0, 0);
        cycle(0, 1, 64'h50, 0, 0, 0);
        cycle(1, 1, 64'h60, 0, 1, 0);
        cycle(0, 1, 64'h70, 0, 1, 0);
        cycle(0, 1, 64'h70, 0, 1, 0);
        cycle(0, 0, '0, 0, 1, 0);
        idle(1);

        // Address wrap, then reset landing mid-flush.
        cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
        cycle(0, 0, '0, 0, 1, 0);
        idle(1);
        chk("wrap_tgt", pred_target_o, 64'h2);
        cycle(1, 0, '0, 0, 0, 0);
        do_reset();
        idle(1);

        // Random traffic, including invalid-top returns and sporadic flushes.
        for (int i = 0; i < 600; i++) begin
            bit cv, rv;
            cv = $urandom_range(0, 1) == 1;
            rv = $urandom_range(0, 1) == 1;
            cycle($urandom_range(0, 15) == 0, cv, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                  rv, !cv && ($urandom_range(0, 15) == 0));
            if (i == 300) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
